// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, handshake
// levels, bus widths and an operand magnitude helper.
package div_unit_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;
    localparam int unsigned CntW         = 6;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of an operand: two's-complement negate when signed and negative.
    function automatic logic [RegBus-1:0] op_mag(input logic [RegBus-1:0] x,
                                                 input logic is_signed);
        return (is_signed && x[RegBus-1]) ? RegBus'(~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32/32 restoring divider, signed or unsigned, result {rem, quo}.
// Optional macro DIV_EARLY_TERM_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              r_state, w_state_nxt;
    logic [CntW-1:0]         r_cnt, w_cnt_nxt;
    logic [64:0]             r_work, w_work_nxt;      // {partial remainder[32:0], quotient[31:0]}
    logic [RegBus-1:0]       r_divisor, w_divisor_nxt;
    logic                    r_neg_q, w_neg_q_nxt;
    logic                    r_neg_r, w_neg_r_nxt;
    logic [DoubleRegBus-1:0] r_result, w_result_nxt;
    logic                    r_ready, w_ready_nxt;

    logic [RegBus-1:0]       w_mag1, w_mag2;
    logic [64:0]             w_shifted;
    logic [RegBus:0]         w_trial;
    logic [RegBus-1:0]       w_quo_fix, w_rem_fix;
    logic                    w_go;

    // Operand magnitudes, one shift-subtract step and final sign correction.
    always_comb begin
        w_mag1    = op_mag(opdata1_i, signed_div_i);
        w_mag2    = op_mag(opdata2_i, signed_div_i);
        w_go      = (start_i == DivStart) && !annul_i;
        w_shifted = r_work << 1;
        w_trial   = w_shifted[64:32] - {1'b0, r_divisor};
        w_quo_fix = r_neg_q ? RegBus'(~r_work[31:0] + 32'd1) : r_work[31:0];
        w_rem_fix = r_neg_r ? RegBus'(~r_work[63:32] + 32'd1) : r_work[63:32];
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        unique case (r_state)
            DivFree: begin
                w_result_nxt = {ZeroWord, ZeroWord};
                w_ready_nxt  = DivResultNotReady;
                if (w_go) begin
                    if (opdata2_i == ZeroWord) begin
                        w_state_nxt = DivByZero;
`ifdef DIV_EARLY_TERM_EN
                    end else if (w_mag1 < w_mag2) begin
                        w_state_nxt  = DivEnd;
                        w_result_nxt = {opdata1_i, ZeroWord};
                        w_ready_nxt  = DivResultReady;
`endif
                    end else begin
                        w_state_nxt   = DivOn;
                        w_cnt_nxt     = '0;
                        w_work_nxt    = {33'd0, w_mag1};
                        w_divisor_nxt = w_mag2;
                        w_neg_q_nxt   = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        w_neg_r_nxt   = signed_div_i && opdata1_i[31];
                    end
                end
            end
            DivByZero: begin
                if (!w_go) begin
                    w_state_nxt = DivFree;
                end else begin
                    w_state_nxt  = DivEnd;
                    w_result_nxt = {ZeroWord, ZeroWord};
                    w_ready_nxt  = DivResultReady;
                end
            end
            DivOn: begin
                if (!w_go) begin
                    w_state_nxt = DivFree;
                end else if (r_cnt != CntW'(RegBus)) begin
                    w_cnt_nxt  = r_cnt + CntW'(1);
                    w_work_nxt = w_trial[RegBus] ? w_shifted
                                                 : {w_trial, w_shifted[31:1], 1'b1};
                end else begin
                    w_state_nxt  = DivEnd;
                    w_result_nxt = {w_rem_fix, w_quo_fix};
                    w_ready_nxt  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_result_nxt = {ZeroWord, ZeroWord};
                    w_ready_nxt  = DivResultNotReady;
                end
            end
            default: w_state_nxt = DivFree;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= DivFree;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: drivers push expected {result, cycle},
// a negedge monitor pops on each rising ready_o and compares.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef DIV_EARLY_TERM_EN
    localparam int ET_LAT = 1;
`else
    localparam int ET_LAT = 34;
`endif

    div_unit dut (
        .clk          (clk),
        .rst          (rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on every rising edge of ready_o.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_o && !prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", 64'(ready_o), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result_o, e.res);
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev = ready_o;
        end
    end

    // One full handshake; operands are scrambled mid-run and must be ignored.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        exp_t e;
        logic got;
        @(posedge clk); #1;
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        e.res = exp; e.cyc = cyc + lat;
        sb_q.push_back(e);
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(posedge clk); #1;
            if (ready_o) got = 1'b1;
            else if (k == 2) begin
                opdata1_i = ~a; opdata2_i = b ^ 32'h5; signed_div_i = ~sgn;
            end
        end
        if (!got) chk("ready_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        chk("hold_ready", 64'(ready_o), 64'd1);
        chk("hold_result", result_o, exp);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("drop_ready", 64'(ready_o), 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        #2;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        do_div(1'b0, 32'd5, 32'd0, 64'd0, 2);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        do_div(1'b0, 32'd3, 32'd10, 64'h00000003_00000000, ET_LAT);
        do_div(1'b1, 32'hFFFFFFFD, 32'd10, 64'hFFFFFFFD_00000000, ET_LAT);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, ET_LAT);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);
        do_div(1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, 34);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        do_div(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 34);

        // Annul in cycle 10, held with start high: no result may ever appear.
        @(posedge clk); #1;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 annul_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        do_div(1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 34);

        // Reset in cycle 20 of a division: outputs clear at once, no result.
        @(posedge clk); #1;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0; start_i = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        chk("midrst_no_ready", 64'(seen), 64'd0);
        do_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 34);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
